// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: default widths, write-select
// encodings and the FSM state type.
package mem_stage_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 8;
  localparam int TMO_W_DEF  = 4;

  localparam logic [1:0] WDST_NONE  = 2'b00;
  localparam logic [1:0] WDST_REG1  = 2'b01;
  localparam logic [1:0] WDST_REG15 = 2'b10;
  localparam logic [1:0] WDST_BOTH  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  function automatic logic is_mem_op(input logic mrd, input logic mwr);
    return mrd | mwr;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Bundle of execute-side, data-memory and writeback signals around the memory stage.
// The stage uses the slave view; the surrounding pipeline/memory use the master view.
interface mem_stage_if
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              ex_valid;
  logic              ex_ready;
  logic [DATA_W-1:0] ex_upper;
  logic [DATA_W-1:0] ex_lower;
  logic [DATA_W-1:0] ex_sdata;
  logic [3:0]        ex_rd;
  logic [1:0]        ex_wdst;
  logic              ex_mrd;
  logic              ex_mwr;
  logic              ex_halt;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              wb_valid;
  logic [3:0]        wb_rd;
  logic [DATA_W-1:0] wb_data1;
  logic [DATA_W-1:0] wb_data15;
  logic [1:0]        wb_wdst;

  logic              halted;
  logic              mem_err;

  modport slave (
    input  ex_valid, ex_upper, ex_lower, ex_sdata, ex_rd, ex_wdst, ex_mrd, ex_mwr, ex_halt,
    input  mem_ack, mem_rdata,
    output ex_ready, mem_req, mem_we, mem_addr, mem_wdata,
    output wb_valid, wb_rd, wb_data1, wb_data15, wb_wdst, halted, mem_err
  );

  modport master (
    output ex_valid, ex_upper, ex_lower, ex_sdata, ex_rd, ex_wdst, ex_mrd, ex_mwr, ex_halt,
    output mem_ack, mem_rdata,
    input  ex_ready, mem_req, mem_we, mem_addr, mem_wdata,
    input  wb_valid, wb_rd, wb_data1, wb_data15, wb_wdst, halted, mem_err
  );

endinterface

// File: rtl/mem_wait_timer.sv
// Wait counter for outstanding memory requests. tc flags the enabled cycle whose
// increment would bring the count to its all-ones terminal value.
module mem_wait_timer #(
  parameter int TMO_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [TMO_W-1:0] LAST = TMO_W'((1 << TMO_W) - 2);

  logic [TMO_W-1:0] count;

  assign tc = en && (count == LAST);

  // counter register: clear has priority over increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: registers execute results, runs the req/ack data-memory
// handshake for loads/stores and emits one writeback record per instruction.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int TMO_W  = TMO_W_DEF
) (
  input logic      clk,
  input logic      rst,
  mem_stage_if.slave bus
);

  state_t state;
  state_t state_nxt;

  logic take;
  logic acked;
  logic timeout;
  logic tmr_clr;
  logic tmr_en;
  logic tmr_tc;
  logic is_load;

  logic [DATA_W-1:0] cap_upper;
  logic [DATA_W-1:0] cap_lower;
  logic [DATA_W-1:0] cap_sdata;
  logic [3:0]        cap_rd;
  logic [1:0]        cap_wdst;
  logic              cap_mrd;
  logic              cap_mwr;

  // A load that is also flagged as a store is executed as a store.
  assign is_load = cap_mrd && !cap_mwr;

  assign bus.ex_ready  = (state == ST_IDLE);
  assign bus.mem_req   = (state == ST_ACCESS);
  assign bus.mem_we    = cap_mwr;
  assign bus.mem_addr  = cap_lower[ADDR_W-1:0];
  assign bus.mem_wdata = cap_sdata;

  mem_wait_timer #(.TMO_W(TMO_W)) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (tmr_clr),
    .en  (tmr_en),
    .tc  (tmr_tc)
  );

  // next-state and handshake strobes
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    acked     = 1'b0;
    timeout   = 1'b0;
    case (state)
      ST_IDLE: begin
        take = bus.ex_valid;
        if (bus.ex_valid) begin
          if (bus.ex_halt) begin
            state_nxt = ST_HALTED;
          end else if (is_mem_op(bus.ex_mrd, bus.ex_mwr)) begin
            state_nxt = ST_ACCESS;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        acked   = bus.mem_ack;
        timeout = !bus.mem_ack && tmr_tc;
        if (acked || timeout) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_ACCESS;
        end
      end
      ST_HALTED: begin
        state_nxt = ST_HALTED;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    tmr_en  = (state == ST_ACCESS) && !bus.mem_ack;
    tmr_clr = (state != ST_ACCESS) || acked || timeout;
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // capture registers, writeback record and sticky flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_upper     <= '0;
      cap_lower     <= '0;
      cap_sdata     <= '0;
      cap_rd        <= 4'd0;
      cap_wdst      <= WDST_NONE;
      cap_mrd       <= 1'b0;
      cap_mwr       <= 1'b0;
      bus.wb_valid  <= 1'b0;
      bus.wb_rd     <= 4'd0;
      bus.wb_data1  <= '0;
      bus.wb_data15 <= '0;
      bus.wb_wdst   <= WDST_NONE;
      bus.halted    <= 1'b0;
      bus.mem_err   <= 1'b0;
    end else begin
      bus.wb_valid <= 1'b0;
      bus.halted   <= bus.halted | (state == ST_HALTED);
      if (take) begin
        cap_upper <= bus.ex_upper;
        cap_lower <= bus.ex_lower;
        cap_sdata <= bus.ex_sdata;
        cap_rd    <= bus.ex_rd;
        cap_wdst  <= bus.ex_wdst;
        cap_mrd   <= bus.ex_mrd;
        cap_mwr   <= bus.ex_mwr;
        // halt and ALU ops retire straight from the execute fields
        if (bus.ex_halt || !is_mem_op(bus.ex_mrd, bus.ex_mwr)) begin
          bus.wb_valid  <= 1'b1;
          bus.wb_rd     <= bus.ex_rd;
          bus.wb_data1  <= bus.ex_lower;
          bus.wb_data15 <= bus.ex_upper;
          bus.wb_wdst   <= bus.ex_halt ? WDST_NONE : bus.ex_wdst;
        end
        if (!bus.ex_halt && bus.ex_mrd && bus.ex_mwr) begin
          bus.mem_err <= 1'b1;
        end
      end else if (acked) begin
        bus.wb_valid  <= 1'b1;
        bus.wb_rd     <= cap_rd;
        bus.wb_data1  <= is_load ? bus.mem_rdata : cap_lower;
        bus.wb_data15 <= cap_upper;
        bus.wb_wdst   <= is_load ? cap_wdst : WDST_NONE;
      end else if (timeout) begin
        bus.wb_valid  <= 1'b1;
        bus.wb_rd     <= cap_rd;
        bus.wb_data1  <= cap_lower;
        bus.wb_data15 <= cap_upper;
        bus.wb_wdst   <= WDST_NONE;
        bus.mem_err   <= 1'b1;
      end
    end
  end

endmodule
